// File: rtl/vend_pkg.sv
// Shared types and helpers for the parametrised vending controller.
package vend_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_e;

  // Coin acceptor select codes.
  localparam logic [1:0] COIN_1  = 2'b00;
  localparam logic [1:0] COIN_2  = 2'b01;
  localparam logic [1:0] COIN_5  = 2'b10;
  localparam logic [1:0] COIN_10 = 2'b11;

  // Unit value of a coin select code.
  function automatic logic [3:0] coin_value(input logic [1:0] coin_sel);
    logic [3:0] val;
    case (coin_sel)
      COIN_1:  val = 4'd1;
      COIN_2:  val = 4'd2;
      COIN_5:  val = 4'd5;
      default: val = 4'd10;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_ctrl_param.sv
// Vending controller: accumulates coin credit against PRICE, strobes a
// dispense, then pays change (or a cancel refund) as single-unit pulses.
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int CW         = 8,
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_vld,
  input  logic [1:0]    coin_sel,
  input  logic          cancel,
  output logic          dout,
  output logic          ret_pulse,
  output logic          coin_rej,
  output logic          busy,
  output logic [CW-1:0] credit
);

  // Reject illegal parameter combinations at elaboration.
  if (PRICE < 1) begin : g_chk_price_min
    $error("vend_ctrl_param: PRICE must be at least 1");
  end
  if (PRICE > MAX_CREDIT) begin : g_chk_price_max
    $error("vend_ctrl_param: PRICE must not exceed MAX_CREDIT");
  end
  if ((MAX_CREDIT + 10) >= (2 ** CW)) begin : g_chk_width
    $error("vend_ctrl_param: CW too narrow for MAX_CREDIT plus largest coin");
  end

  localparam logic [CW:0]   PRICE_W = (CW + 1)'(PRICE);
  localparam logic [CW:0]   MAX_W   = (CW + 1)'(MAX_CREDIT);
  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          dout_q, dout_d;
  logic          ret_q, ret_d;
  logic          rej_q, rej_d;
  logic          busy_q, busy_d;
  logic [CW:0]   sum;

  // Next-state, next-credit and next-output logic.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    rej_d    = 1'b0;
    // One extra bit so the overflow test cannot wrap.
    sum      = {1'b0, credit_q} + (CW + 1)'(coin_value(coin_sel));

    case (state_q)
      IDLE, COLLECT: begin
        if ((state_q == COLLECT) && cancel) begin
          // Cancel wins over a coin offered in the same cycle.
          state_d = CHANGE;
          rej_d   = coin_vld;
        end else if (coin_vld) begin
          if (sum > MAX_W) begin
            rej_d = 1'b1;
          end else begin
            credit_d = sum[CW-1:0];
            state_d  = (sum >= PRICE_W) ? VEND : COLLECT;
          end
        end
      end

      VEND: begin
        // Only entered with credit >= PRICE, so no underflow here.
        rej_d    = coin_vld;
        credit_d = credit_q - PRICE_C;
        state_d  = (credit_q != PRICE_C) ? CHANGE : IDLE;
      end

      CHANGE: begin
        rej_d = coin_vld;
        if (credit_q <= ONE_C) begin
          credit_d = '0;
          state_d  = IDLE;
        end else begin
          credit_d = credit_q - ONE_C;
        end
      end

      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    dout_d = (state_d == VEND);
    ret_d  = (state_d == CHANGE);
    busy_d = dout_d | ret_d;
  end

  // State, credit and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      dout_q   <= 1'b0;
      ret_q    <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      dout_q   <= dout_d;
      ret_q    <= ret_d;
      rej_q    <= rej_d;
      busy_q   <= busy_d;
    end
  end

  assign dout      = dout_q;
  assign ret_pulse = ret_q;
  assign coin_rej  = rej_q;
  assign busy      = busy_q;
  assign credit    = credit_q;

endmodule
